intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
Interrupt controller that sequences the datapath's exception path.
- Latches and prioritises N_SRC synchronous interrupt sources against a software-writable enable mask.
- Drives the datapath's irq (one-cycle pulse) and EAddr vector, then holds further interrupts off until the handler's return is decoded.
- Sits beside the control unit; its irq/EAddr outputs feed the datapath, and return comes from the decoder.

Parameters:
- N_SRC, 4, number of interrupt sources (1..16)
- VEC_BASE, 32'h0000_0100, handler address for source 0
- VEC_STRIDE, 8, byte spacing between consecutive source vectors (multiple of 4)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- src_req  in  N_SRC  interrupt request lines, synchronous to clk; bit 0 = highest priority
- mask_we  in  1  write strobe for enable mask
- mask_wd  in  N_SRC  new enable mask (1 = enabled)
- ret  in  1  handler return instruction decoded this cycle (drives datapath return)
- irq  out  1  take-interrupt pulse to datapath (saves EPC, redirects PC)
- EAddr  out  32  handler vector, valid while irq=1
- in_service  out  1  handler currently executing
- active_id  out  $clog2(N_SRC) (min 1)  id of source being serviced
- pending  out  N_SRC  latched pending requests (unmasked view)

Behaviour:
- Reset values: irq=0, EAddr=0, in_service=0, active_id=0, pending=0, mask=0, src_q=0, state=IDLE.
- Edge detect: a rising edge is src_req & ~src_q, with src_q registered each cycle. A source held high through reset therefore registers an edge on the first cycle after reset.
- Pending update: each cycle, pending <= (pending & ~clr) | rise. If set and clear hit the same bit in the same cycle, set wins.
- Masking: mask <= mask_wd on mask_we, effective the next cycle. Masking does not clear pending; eligible = pending & mask.
- FSM:
  - IDLE: if eligible != 0, go to TAKE. Latch id = lowest set index of eligible and EAddr = VEC_BASE + id*VEC_STRIDE (32-bit wrap). Set clr for that bit.
  - TAKE (1 cycle): irq=1 and EAddr held. Next state is SERVICE with in_service=1.
  - SERVICE: irq=0. New edges keep latching into pending. On ret=1, go to IDLE and clear in_service.
- irq is never asserted in the same cycle as ret, so the saved EPC is not overwritten during return. Minimum interrupt-to-interrupt spacing is ret cycle + 1 IDLE cycle + TAKE.
- ret in IDLE or TAKE is ignored, with no state change.
- mask_we during TAKE or SERVICE does not affect the interrupt already taken.
- Latency: an edge arriving in IDLE produces irq 2 cycles later (cycle 0 sets pending, cycle 1 latches id / enters TAKE, cycle 2 irq).
- EAddr holds its value after TAKE until the next take.
- rst asserted in any state returns everything to reset values on the next clock edge; pending requests are discarded.

Optional Feature:
INTR_CTRL_LEVEL_EN
- Defined: sources are level-sensitive. Edge detect and pending latching are bypassed, pending = src_req, and clr has no effect; the handler must deassert the source before ret, otherwise it is re-taken.
- Undefined: edge-triggered latching as described above (default).

Decomposition:
- Package intr_ctrl_pkg: state enum (IDLE, TAKE, SERVICE), default VEC_BASE/VEC_STRIDE constants, ID_W function ($clog2 with min 1).
- Sub-module intr_prio_enc: combinational lowest-index-first encoder (valid, id) parameterised by N_SRC.

Test Plan:
- Reset, mask=4'b1111, pulse src_req[2] for 1 cycle -> irq high exactly 2 cycles later for 1 cycle, EAddr=32'h110, active_id=2, pending[2] cleared.
- src_req[1] and [3] rise in the same cycle -> id 1 taken (EAddr=32'h108); after ret, id 3 taken (EAddr=32'h118) with irq spaced ≥2 cycles after ret.
- mask=4'b0000, pulse src_req[0] -> no irq, pending=4'b0001; write mask=4'b0001 -> irq 2 cycles after the write cycle, EAddr=32'h100.
- In SERVICE, pulse src_req[0] and hold ret low 10 cycles -> no irq, pending[0]=1; assert ret -> irq for id 0 arrives 2 cycles later, never in the ret cycle.
- Assert rst during SERVICE with pending=4'b1000 -> next cycle in_service=0, pending=0, irq stays 0.
- INTR_CTRL_LEVEL_EN build: hold src_req[1] high across ret -> id 1 re-taken; deassert before ret -> no further irq.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state type,
// default vector layout and the source-id width helper.
package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TAKE,
        SERVICE
    } state_e;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
    localparam int          DEF_VEC_STRIDE = 8;

    // Width of a source id; a single source still gets a 1-bit id.
    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational priority encoder: reports the lowest set index of req
// together with a valid flag.
module intr_prio_enc
    import intr_ctrl_pkg::*;
#(
    parameter  int N_SRC = 4,
    localparam int ID_W  = id_w(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    // Scan from the top down so the lowest index is the last to win.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches and prioritises sources, pulses irq with the
// handler vector, and blocks further interrupts until ret. Level-sensitive
// sources are selected by defining INTR_CTRL_LEVEL_EN.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter  int          N_SRC      = 4,
    parameter  logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter  int          VEC_STRIDE = DEF_VEC_STRIDE,
    localparam int          ID_W       = id_w(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_req,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wd,
    input  logic             ret,
    output logic             irq,
    output logic [31:0]      EAddr,
    output logic             in_service,
    output logic [ID_W-1:0]  active_id,
    output logic [N_SRC-1:0] pending
);

    state_e            state_q, state_d;
    logic [N_SRC-1:0]  mask_q, mask_d;
    logic              irq_q, irq_d;
    logic              in_service_q, in_service_d;
    logic [31:0]       eaddr_q, eaddr_d;
    logic [ID_W-1:0]   active_id_q, active_id_d;
    logic [N_SRC-1:0]  eligible;
    logic              enc_valid;
    logic [ID_W-1:0]   enc_id;

    assign eligible = pending & mask_q;

    intr_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .req   (eligible),
        .valid (enc_valid),
        .id    (enc_id)
    );

`ifdef INTR_CTRL_LEVEL_EN
    assign pending = src_req;
`else
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] clr;
    logic             take;

    assign take = (state_q == IDLE) && enc_valid;

    // A new edge on the bit being taken this cycle must survive the clear.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr[i] = take && (enc_id == ID_W'(i));
        end
        pending_d = (pending_q & ~clr) | (src_req & ~src_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q     <= '0;
            pending_q <= '0;
        end else begin
            src_q     <= src_req;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
`endif

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_we ? mask_wd : mask_q;
        irq_d        = 1'b0;
        in_service_d = in_service_q;
        eaddr_d      = eaddr_q;
        active_id_d  = active_id_q;
        unique case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_d     = TAKE;
                    irq_d       = 1'b1;
                    active_id_d = enc_id;
                    eaddr_d     = VEC_BASE + 32'(enc_id) * 32'(VEC_STRIDE);
                end
            end
            TAKE: begin
                state_d      = SERVICE;
                in_service_d = 1'b1;
            end
            SERVICE: begin
                // ret leaves via IDLE, so irq can never coincide with ret.
                if (ret) begin
                    state_d      = IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            irq_q        <= 1'b0;
            in_service_q <= 1'b0;
            eaddr_q      <= '0;
            active_id_q  <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            irq_q        <= irq_d;
            in_service_q <= in_service_d;
            eaddr_q      <= eaddr_d;
            active_id_q  <= active_id_d;
        end
    end

    assign irq        = irq_q;
    assign EAddr      = eaddr_q;
    assign in_service = in_service_q;
    assign active_id  = active_id_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: a table of per-cycle input/expected
// records plus hand-written multi-cycle sequences (edge build by default,
// level build when INTR_CTRL_LEVEL_EN is defined).
module tb_intr_ctrl;

   typedef struct {
      logic        rst;
      logic [3:0]  src;
      logic        mwe;
      logic [3:0]  mwd;
      logic        ret;
      logic        irq;
      logic [31:0] eaddr;
      logic        insvc;
      logic [1:0]  aid;
      logic [3:0]  pend;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [3:0]  src_req;
   logic        mask_we;
   logic [3:0]  mask_wd;
   logic        ret;
   logic        irq;
   logic [31:0] EAddr;
   logic        in_service;
   logic [1:0]  active_id;
   logic [3:0]  pending;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   intr_ctrl #(
      .N_SRC      (4),
      .VEC_BASE   (32'h0000_0100),
      .VEC_STRIDE (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .src_req    (src_req),
      .mask_we    (mask_we),
      .mask_wd    (mask_wd),
      .ret        (ret),
      .irq        (irq),
      .EAddr      (EAddr),
      .in_service (in_service),
      .active_id  (active_id),
      .pending    (pending)
   );

   // Free-running 10-unit clock; inputs change on negedge, outputs are
   // sampled 1 unit after each posedge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [3:0] s, input logic we,
                               input logic [3:0] wd, input logic rt, input logic ei,
                               input logic [31:0] ea, input logic es,
                               input logic [1:0] eid, input logic [3:0] ep);
      vec_t v;
      v.rst = r;   v.src = s;    v.mwe = we;  v.mwd = wd;  v.ret = rt;
      v.irq = ei;  v.eaddr = ea; v.insvc = es; v.aid = eid; v.pend = ep;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      rst     = v.rst;
      src_req = v.src;
      mask_we = v.mwe;
      mask_wd = v.mwd;
      ret     = v.ret;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input vec_t v);
      checks++;
      if (irq !== v.irq || EAddr !== v.eaddr || in_service !== v.insvc ||
          active_id !== v.aid || pending !== v.pend) begin
         errors++;
         $display("[TB] FAIL %s: got irq=%0b EAddr=%h in_service=%0b active_id=%0d pending=%b, expected irq=%0b EAddr=%h in_service=%0b active_id=%0d pending=%b",
                  name, irq, EAddr, in_service, active_id, pending,
                  v.irq, v.eaddr, v.insvc, v.aid, v.pend);
      end
   endtask

   task automatic runVec(input string name, input vec_t v);
      applyStimulus(v);
      checkOutput(name, v);
   endtask

   // Main test: fill the vector table, play it, then the hand sequences.
   initial begin
      rst = 1'b1; src_req = '0; mask_we = 1'b0; mask_wd = '0; ret = 1'b0;

`ifdef INTR_CTRL_LEVEL_EN
      //               rst src    we wd     ret irq eaddr        svc id pend
      vecs.push_back(mk(1, 4'h0, 0, 4'h0, 0,  0, 32'h0,        0, 0, 4'h0));
      vecs.push_back(mk(0, 4'h0, 1, 4'hF, 0,  0, 32'h0,        0, 0, 4'h0));
      vecs.push_back(mk(0, 4'h2, 0, 4'h0, 0,  1, 32'h108,      0, 1, 4'h2));
      vecs.push_back(mk(0, 4'h2, 0, 4'h0, 0,  0, 32'h108,      1, 1, 4'h2));
      vecs.push_back(mk(0, 4'h2, 0, 4'h0, 1,  0, 32'h108,      0, 1, 4'h2));
      vecs.push_back(mk(0, 4'h2, 0, 4'h0, 0,  1, 32'h108,      0, 1, 4'h2));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 0,  0, 32'h108,      1, 1, 4'h0));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1,  0, 32'h108,      0, 1, 4'h0));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 0,  0, 32'h108,      0, 1, 4'h0));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 0,  0, 32'h108,      0, 1, 4'h0));
`else
      //               rst src    we wd     ret irq eaddr        svc id pend
      vecs.push_back(mk(1, 4'h0, 0, 4'h0, 0,  0, 32'h0,        0, 0, 4'h0));
      vecs.push_back(mk(0, 4'h0, 1, 4'hF, 0,  0, 32'h0,        0, 0, 4'h0));
      // single pulse on source 2
      vecs.push_back(mk(0, 4'h4, 0, 4'h0, 0,  0, 32'h0,        0, 0, 4'h4));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 0,  1, 32'h110,      0, 2, 4'h0));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 0,  0, 32'h110,      1, 2, 4'h0));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1,  0, 32'h110,      0, 2, 4'h0));
      // sources 1 and 3 together: 1 first, 3 after ret
      vecs.push_back(mk(0, 4'hA, 0, 4'h0, 0,  0, 32'h110,      0, 2, 4'hA));
      vecs.push_back(mk(0, 4'hA, 0, 4'h0, 0,  1, 32'h108,      0, 1, 4'h8));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 0,  0, 32'h108,      1, 1, 4'h8));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1,  0, 32'h108,      0, 1, 4'h8));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 0,  1, 32'h118,      0, 3, 4'h0));
      // ret during TAKE and during IDLE is ignored
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1,  0, 32'h118,      1, 3, 4'h0));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1,  0, 32'h118,      0, 3, 4'h0));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1,  0, 32'h118,      0, 3, 4'h0));
      // masked pending, then unmask
      vecs.push_back(mk(0, 4'h0, 1, 4'h0, 0,  0, 32'h118,      0, 3, 4'h0));
      vecs.push_back(mk(0, 4'h1, 0, 4'h0, 0,  0, 32'h118,      0, 3, 4'h1));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 0,  0, 32'h118,      0, 3, 4'h1));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 0,  0, 32'h118,      0, 3, 4'h1));
      vecs.push_back(mk(0, 4'h0, 1, 4'h1, 0,  0, 32'h118,      0, 3, 4'h1));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 0,  1, 32'h100,      0, 0, 4'h0));
      vecs.push_back(mk(0, 4'h0, 0, 4'h0, 0,  0, 32'h100,      1, 0, 4'h0));
      // in SERVICE: new edge on 0 plus a mask write, no effect on current
      vecs.push_back(mk(0, 4'h1, 1, 4'hF, 0,  0, 32'h100,      1, 0, 4'h1));
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         runVec($sformatf("vec%0d", i), vecs[i]);
      end

`ifndef INTR_CTRL_LEVEL_EN
      // Long service with a pending request held off until ret.
      for (int i = 0; i < 10; i++) begin
         runVec($sformatf("hold%0d", i),
                mk(0, 4'h0, 0, 4'h0, 0, 0, 32'h100, 1, 0, 4'h1));
      end
      runVec("ret_cycle",   mk(0, 4'h0, 0, 4'h0, 1, 0, 32'h100, 0, 0, 4'h1));
      runVec("retake_irq",  mk(0, 4'h0, 0, 4'h0, 0, 1, 32'h100, 0, 0, 4'h0));
      runVec("retake_svc",  mk(0, 4'h0, 0, 4'h0, 0, 0, 32'h100, 1, 0, 4'h0));

      // Reset during SERVICE discards pending and mask.
      runVec("pend3_set",   mk(0, 4'h8, 0, 4'h0, 0, 0, 32'h100, 1, 0, 4'h8));
      runVec("pend3_hold",  mk(0, 4'h0, 0, 4'h0, 0, 0, 32'h100, 1, 0, 4'h8));
      runVec("rst_in_svc",  mk(1, 4'h0, 0, 4'h0, 0, 0, 32'h0,   0, 0, 4'h0));
      runVec("post_rst0",   mk(0, 4'h0, 0, 4'h0, 0, 0, 32'h0,   0, 0, 4'h0));
      runVec("post_rst_p",  mk(0, 4'h1, 0, 4'h0, 0, 0, 32'h0,   0, 0, 4'h1));
      runVec("mask_rst0",   mk(0, 4'h0, 0, 4'h0, 0, 0, 32'h0,   0, 0, 4'h1));
      runVec("mask_rst1",   mk(0, 4'h0, 0, 4'h0, 0, 0, 32'h0,   0, 0, 4'h1));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
